// File: rtl/key_scan_pkg.sv
// Shared constants, candidate encoding and scan FSM states for the keypad scanner.
package key_scan_pkg;

  localparam int         KEY_NUM   = 12;
  localparam logic [3:0] LAST_SEL  = 4'd11;
  // Sweep candidate is {valid, idx}; valid=0 means no key seen.
  localparam logic [4:0] CAND_NONE = 5'b0_0000;

  localparam logic [3:0] POS_KEY_1    = 4'd0;
  localparam logic [3:0] POS_KEY_2    = 4'd1;
  localparam logic [3:0] POS_KEY_3    = 4'd2;
  localparam logic [3:0] POS_KEY_4    = 4'd3;
  localparam logic [3:0] POS_KEY_5    = 4'd4;
  localparam logic [3:0] POS_KEY_6    = 4'd5;
  localparam logic [3:0] POS_KEY_7    = 4'd6;
  localparam logic [3:0] POS_KEY_8    = 4'd7;
  localparam logic [3:0] POS_KEY_9    = 4'd8;
  localparam logic [3:0] POS_KEY_STAR = 4'd9;
  localparam logic [3:0] POS_KEY_0    = 4'd10;
  localparam logic [3:0] POS_KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_FRAME  = 2'd2
  } scan_state_t;

  function automatic logic [4:0] make_cand(input logic [3:0] idx);
    return {1'b1, idx};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Sweep-to-sweep debouncer producing press (and, with KEY_RELEASE_EVT_EN, release) events.
module key_debounce
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame,
  input  logic [4:0] cand,
  output logic       evt_valid,
  output logic [3:0] evt_code,
  output logic       evt_rel
);

  logic [4:0] last_cand_r;
  logic [4:0] stable_r;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       confirm_s;

  // Next run-length count and confirmation; the event is combinational so it
  // can be loaded into the output register on the edge ending the frame cycle.
  always_comb begin
    cnt_nxt_s = 4'd1;
    if (cand == last_cand_r) begin
      if (cnt_r == 4'(DEBOUNCE_CNT)) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_nxt_s = 4'd1;
    end
    confirm_s = frame && (cnt_nxt_s == 4'(DEBOUNCE_CNT)) && (cand != stable_r);
  end

  // Event generation from a confirmed change of the stable key.
  always_comb begin
    evt_valid = 1'b0;
    evt_code  = 4'd0;
    evt_rel   = 1'b0;
    if (confirm_s) begin
      if (cand[4]) begin
        evt_valid = 1'b1;
        evt_code  = cand[3:0];
      end else begin
`ifdef KEY_RELEASE_EVT_EN
        evt_valid = 1'b1;
        evt_code  = stable_r[3:0];
        evt_rel   = 1'b1;
`else
        evt_valid = 1'b0;
`endif
      end
    end else begin
      evt_valid = 1'b0;
    end
  end

  // Debounce state, updated once per sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cand_r <= CAND_NONE;
      cnt_r       <= 4'd0;
      stable_r    <= CAND_NONE;
    end else if (frame) begin
      last_cand_r <= cand;
      cnt_r       <= cnt_nxt_s;
      if (confirm_s) begin
        stable_r <= cand;
      end else begin
        stable_r <= stable_r;
      end
    end else begin
      last_cand_r <= last_cand_r;
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: sweeps 12 mux positions, debounces, and emits key events
// over valid/ready. Build macro KEY_RELEASE_EVT_EN enables release events.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] sel_o,
  input  logic       key_i,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_rel,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  scan_state_t    state_r;
  logic [SCW-1:0] settle_cnt_r;
  logic [3:0]     sel_r;
  logic [4:0]     best_r;
  logic           frame_s;
  logic           evt_valid_s;
  logic [3:0]     evt_code_s;
  logic           evt_rel_s;
  logic           key_valid_r;
  logic [3:0]     key_code_r;
  logic           key_rel_r;
  logic           overrun_r;

  assign frame_s = (state_r == ST_FRAME);

  // Scan FSM; positions are visited in ascending order, so the first hit is the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_SETTLE;
      settle_cnt_r <= '0;
      sel_r        <= 4'd0;
      best_r       <= CAND_NONE;
    end else begin
      case (state_r)
        ST_SETTLE: begin
          if (settle_cnt_r == SCW'(SETTLE_CYC - 1)) begin
            settle_cnt_r <= '0;
            state_r      <= ST_SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + SCW'(1);
          end
        end
        ST_SAMPLE: begin
          if (key_i && !best_r[4]) begin
            best_r <= make_cand(sel_r);
          end else begin
            best_r <= best_r;
          end
          if (sel_r == LAST_SEL) begin
            state_r <= ST_FRAME;
          end else begin
            sel_r   <= sel_r + 4'd1;
            state_r <= ST_SETTLE;
          end
        end
        ST_FRAME: begin
          sel_r   <= 4'd0;
          best_r  <= CAND_NONE;
          state_r <= ST_SETTLE;
        end
        default: begin
          state_r      <= ST_SETTLE;
          settle_cnt_r <= '0;
          sel_r        <= 4'd0;
          best_r       <= CAND_NONE;
        end
      endcase
    end
  end

  key_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame     (frame_s),
    .cand      (best_r),
    .evt_valid (evt_valid_s),
    .evt_code  (evt_code_s),
    .evt_rel   (evt_rel_s)
  );

  // One-entry output holding register; an event arriving while it is full and not draining is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
      key_rel_r   <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (evt_valid_s) begin
      if (!key_valid_r || key_ready) begin
        key_valid_r <= 1'b1;
        key_code_r  <= evt_code_s;
        key_rel_r   <= evt_rel_s;
        overrun_r   <= 1'b0;
      end else begin
        overrun_r   <= 1'b1;
      end
    end else begin
      overrun_r <= 1'b0;
      if (key_ready) begin
        key_valid_r <= 1'b0;
      end else begin
        key_valid_r <= key_valid_r;
      end
    end
  end

  assign sel_o     = sel_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign key_rel   = key_rel_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed self-checking bench for key_scan_ctrl; the key mux is modelled by a pressed-key mask.
module tb_key_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sel_o;
  logic        key_i;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_rel;
  logic        key_ready;
  logic        overrun;
  logic [15:0] mask;

  int          tests;
  int          fails;
  logic [4:0]  ev_q[$];
  int          ovr_cnt;

  key_scan_ctrl #(
    .SETTLE_CYC   (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_o     (sel_o),
    .key_i     (key_i),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_rel   (key_rel),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  assign key_i = mask[sel_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event as {rel, code} and every overrun pulse.
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) ev_q.push_back({key_rel, key_code});
    if (rst_n && overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    rst_n     = 1'b0;
    mask      = 16'h0000;
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int eb;
    int o0;
    int bad;
    tests     = 0;
    fails     = 0;
    ovr_cnt   = 0;
    rst_n     = 1'b0;
    mask      = 16'h0000;
    key_ready = 1'b1;
    #1;
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_rel", 32'(key_rel), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // Single key at sel 4: event loads on edge 183 (third frame), drains next edge.
    do_reset();
    mask = 16'h0010;
    eb = ev_q.size();
    wait_edges(182);
    check("k4_before", 32'(key_valid), 32'd0);
    wait_edges(1);
    check("k4_valid", 32'(key_valid), 32'd1);
    check("k4_code", 32'(key_code), 32'd4);
    check("k4_rel", 32'(key_rel), 32'd0);
    wait_edges(1);
    check("k4_drop", 32'(key_valid), 32'd0);
    wait_edges(183);
    check("k4_count", 32'(ev_q.size() - eb), 32'd1);

    // Keys at sel 2 and 9: lowest index wins.
    do_reset();
    mask = 16'h0204;
    eb = ev_q.size();
    wait_edges(61 * 5);
    check("multi_count", 32'(ev_q.size() - eb), 32'd1);
    check("multi_code", 32'(ev_q[eb]), 32'h02);

    // Sel 10 held for two sweeps only: never confirmed.
    do_reset();
    mask = 16'h0400;
    eb = ev_q.size();
    wait_edges(122);
    mask = 16'h0000;
    wait_edges(61 * 4);
    check("short_count", 32'(ev_q.size() - eb), 32'd0);

    // Backpressure: code 0 held, code 11 event dropped with one overrun pulse.
    do_reset();
    key_ready = 1'b0;
    mask = 16'h0001;
    o0 = ovr_cnt;
    wait_edges(183);
    check("bp_valid", 32'(key_valid), 32'd1);
    check("bp_code", 32'(key_code), 32'd0);
    mask = 16'h0800;
    bad = 0;
    for (int k = 184; k <= 400; k++) begin
      wait_edges(1);
      if (!(key_valid === 1'b1 && key_code === 4'd0)) bad++;
      if (k == 366) check("bp_ovr_pulse", 32'(overrun), 32'd1);
      if (k == 367) check("bp_ovr_end", 32'(overrun), 32'd0);
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_ovr_cnt", 32'(ovr_cnt - o0), 32'd1);
    eb = ev_q.size();
    key_ready = 1'b1;
    wait_edges(1);
    check("bp_acc_count", 32'(ev_q.size() - eb), 32'd1);
    check("bp_acc_code", 32'(ev_q[eb]), 32'h00);
    check("bp_after", 32'(key_valid), 32'd0);
    wait_edges(122);
    check("bp_no_more", 32'(ev_q.size() - eb), 32'd1);

    // Press, release, repress sel 7.
    do_reset();
    mask = 16'h0080;
    eb = ev_q.size();
    wait_edges(183);
    mask = 16'h0000;
    wait_edges(183);
    mask = 16'h0080;
    wait_edges(185);
`ifdef KEY_RELEASE_EVT_EN
    check("rel_count", 32'(ev_q.size() - eb), 32'd3);
    check("rel_ev0", 32'(ev_q[eb]), 32'h07);
    check("rel_ev1", 32'(ev_q[eb + 1]), 32'h17);
    check("rel_ev2", 32'(ev_q[eb + 2]), 32'h07);
`else
    check("rel_count", 32'(ev_q.size() - eb), 32'd2);
    check("rel_ev0", 32'(ev_q[eb]), 32'h07);
    check("rel_ev1", 32'(ev_q[eb + 1]), 32'h07);
`endif

    // Asynchronous reset during a pending handshake, mid-sweep.
    do_reset();
    key_ready = 1'b0;
    mask = 16'h0010;
    wait_edges(183 + 30);
    check("ar_valid_pre", 32'(key_valid), 32'd1);
    check("ar_sel_pre", 32'(sel_o), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(key_valid), 32'd0);
    check("ar_code", 32'(key_code), 32'd0);
    check("ar_sel", 32'(sel_o), 32'd0);
    check("ar_ovr", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edges(4);
    check("ar_sel_hold", 32'(sel_o), 32'd0);
    wait_edges(1);
    check("ar_sel_step", 32'(sel_o), 32'd1);
    check("ar_lost", 32'(key_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
